// File: rtl/magnitude_pkg.sv
// Width and latency helpers shared by the square-root pipeline and its bench.
//   root_width(n)   : width of the result root (n)
//   rem_width(n)    : width of the partial remainder register (n+2)
//   pipe_latency(n) : input register plus n recurrence stages (n+1)
package magnitude_pkg;

  localparam int unsigned DEFAULT_DATA_SIZE = 16;

  function automatic int unsigned root_width(input int unsigned n);
    return n;
  endfunction

  function automatic int unsigned rem_width(input int unsigned n);
    return n + 2;
  endfunction

  function automatic int unsigned pipe_latency(input int unsigned n);
    return n + 1;
  endfunction

endpackage

// File: rtl/magnitude_sqrt_stage.sv
// One restoring square-root recurrence stage.
// Brings down the next two radicand bits, tries the trial divisor
// (root<<2)|1 and resolves one root bit.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   rad_prev/rem_prev/root_prev : state from the previous stage
//   rad/rem/root             : registered state for the next stage
module magnitude_sqrt_stage
  import magnitude_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int unsigned STAGE     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [2*DATA_SIZE-1:0]        rad_prev,
  input  logic [rem_width(DATA_SIZE)-1:0] rem_prev,
  input  logic [DATA_SIZE-1:0]          root_prev,
  output logic [2*DATA_SIZE-1:0]        rad,
  output logic [rem_width(DATA_SIZE)-1:0] rem,
  output logic [DATA_SIZE-1:0]          root
);

  localparam int unsigned RW = rem_width(DATA_SIZE);

  logic [RW+1:0]        shifted;
  logic [RW-1:0]        trial;
  logic [RW-1:0]        diff;
  logic [DATA_SIZE-1:0] root_mask;
  logic [DATA_SIZE-1:0] partial;
  logic                 ge;

  always_comb begin
    // Only the low STAGE bits of the incoming root can be non-zero;
    // masking the rest lets synthesis trim the early, narrow stages.
    root_mask = '0;
    for (int unsigned i = 0; i < DATA_SIZE; i++) begin
      if (i < STAGE) root_mask[i] = 1'b1;
    end
    partial = root_prev & root_mask;
    shifted = {rem_prev, rad_prev[2*DATA_SIZE-1 -: 2]};
    trial   = {partial, 2'b01};
    // Compare at full width; the subtraction only matters when it is
    // non-negative, and then the difference always fits RW bits.
    ge      = (shifted >= {2'b00, trial});
    diff    = shifted[RW-1:0] - trial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rad  <= '0;
      rem  <= '0;
      root <= '0;
    end else begin
      rad  <= {rad_prev[2*DATA_SIZE-3:0], 2'b00};
      rem  <= ge ? diff : shifted[RW-1:0];
      root <= {partial[DATA_SIZE-2:0], ge};
    end
  end

endmodule

// File: rtl/magnitude_sqrt.sv
// Pipelined integer square root: data_o = floor(sqrt(data_i)).
// Input register followed by DATA_SIZE recurrence stages, one root bit per
// stage, one sample per clock, no stall. en/sof/eof follow in a shift chain
// of equal depth so they line up with the result.
// Ports:
//   data_clk_i/data_rst_i : clock, synchronous active-high reset
//   data_i [2N]           : unsigned radicand
//   data_en_i/sof_i/eof_i : valid and framing flags
//   data_o [N]            : root; data_en_o/sof_o/eof_o delayed flags
//   data_rst_o/data_clk_o : pass-through copies of reset and clock
module magnitude_sqrt
  import magnitude_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                   data_clk_i,
  input  logic                   data_rst_i,
  input  logic [2*DATA_SIZE-1:0] data_i,
  input  logic                   data_en_i,
  input  logic                   data_sof_i,
  input  logic                   data_eof_i,
  output logic [DATA_SIZE-1:0]   data_o,
  output logic                   data_en_o,
  output logic                   data_sof_o,
  output logic                   data_eof_o,
  output logic                   data_rst_o,
  output logic                   data_clk_o
);

  localparam int unsigned RW  = rem_width(DATA_SIZE);
  localparam int unsigned LAT = pipe_latency(DATA_SIZE);

  logic [2*DATA_SIZE-1:0] rad_pipe  [0:DATA_SIZE];
  logic [RW-1:0]          rem_pipe  [0:DATA_SIZE];
  logic [DATA_SIZE-1:0]   root_pipe [0:DATA_SIZE];

  logic [LAT-1:0] en_sr;
  logic [LAT-1:0] sof_sr;
  logic [LAT-1:0] eof_sr;

  assign data_rst_o = data_rst_i;
  assign data_clk_o = data_clk_i;

  always_ff @(posedge data_clk_i) begin
    if (data_rst_i) begin
      rad_pipe[0] <= '0;
    end else begin
      rad_pipe[0] <= data_i;
    end
  end

  assign rem_pipe[0]  = '0;
  assign root_pipe[0] = '0;

  for (genvar s = 0; s < DATA_SIZE; s++) begin : g_stage
    magnitude_sqrt_stage #(
      .DATA_SIZE (DATA_SIZE),
      .STAGE     (s)
    ) u_stage (
      .clk       (data_clk_i),
      .rst       (data_rst_i),
      .rad_prev  (rad_pipe[s]),
      .rem_prev  (rem_pipe[s]),
      .root_prev (root_pipe[s]),
      .rad       (rad_pipe[s+1]),
      .rem       (rem_pipe[s+1]),
      .root      (root_pipe[s+1])
    );
  end

  // Framing flags are qualified by en on entry so they can never surface
  // on an invalid output slot.
  always_ff @(posedge data_clk_i) begin
    if (data_rst_i) begin
      en_sr  <= '0;
      sof_sr <= '0;
      eof_sr <= '0;
    end else begin
      en_sr  <= {en_sr[LAT-2:0],  data_en_i};
      sof_sr <= {sof_sr[LAT-2:0], data_sof_i & data_en_i};
      eof_sr <= {eof_sr[LAT-2:0], data_eof_i & data_en_i};
    end
  end

  assign data_o     = root_pipe[DATA_SIZE];
  assign data_en_o  = en_sr[LAT-1];
  assign data_sof_o = sof_sr[LAT-1];
  assign data_eof_o = eof_sr[LAT-1];

endmodule

// File: tb/tb_magnitude_sqrt.sv
// Self-checking bench for magnitude_sqrt (DATA_SIZE=16).
module tb_magnitude_sqrt;
  import magnitude_pkg::*;

  localparam int unsigned N   = 16;
  localparam int unsigned LAT = pipe_latency(N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   din = '0;
  logic          en  = 1'b0;
  logic          sof = 1'b0;
  logic          eof = 1'b0;
  logic [15:0]   q;
  logic          q_en, q_sof, q_eof, q_rst, q_clk;

  int unsigned       total = 0;
  int unsigned       bad   = 0;
  longint unsigned   cyc   = 0;
  logic              mon_on = 1'b0;

  typedef struct {
    logic [15:0]     root;
    logic            sof;
    logic            eof;
    longint unsigned due;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  magnitude_sqrt #(.DATA_SIZE(N)) dut (
    .data_clk_i (clk),
    .data_rst_i (rst),
    .data_i     (din),
    .data_en_i  (en),
    .data_sof_i (sof),
    .data_eof_i (eof),
    .data_o     (q),
    .data_en_o  (q_en),
    .data_sof_o (q_sof),
    .data_eof_o (q_eof),
    .data_rst_o (q_rst),
    .data_clk_o (q_clk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Largest r with r*r <= x, by binary search on 64-bit products.
  function automatic logic [15:0] ref_sqrt(input logic [31:0] x);
    longint unsigned lo = 0;
    longint unsigned hi = 65535;
    longint unsigned mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // Drive one input cycle; inputs are sampled at the next rising edge,
  // so the result is due LAT edges from now.
  task automatic drive(input logic [31:0] x, input logic e, input logic s, input logic f);
    din = x; en = e; sof = s; eof = f;
    if (e) sb.push_back('{ref_sqrt(x), s, f, cyc + LAT});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every output slot is checked away from the edge.
  always @(negedge clk) begin
    if (mon_on) begin
      total++;
      if (q_en) begin
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got en_o=1 data=%h at cycle %0d, want no output", q, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (q !== mon_e.root || q_sof !== mon_e.sof || q_eof !== mon_e.eof || cyc !== mon_e.due) begin
            bad++;
            $display("FAIL scoreboard: got data=%h sof=%b eof=%b cycle=%0d, want data=%h sof=%b eof=%b cycle=%0d",
                     q, q_sof, q_eof, cyc, mon_e.root, mon_e.sof, mon_e.eof, mon_e.due);
          end
        end
      end else begin
        if (q_sof !== 1'b0 || q_eof !== 1'b0) begin
          bad++;
          $display("FAIL flags_without_en: got sof_o=%b eof_o=%b with en_o=0, want 0 0", q_sof, q_eof);
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
          bad++;
          mon_e = sb.pop_front();
          $display("FAIL missing_output: got en_o=0 at cycle %0d, want data=%h", cyc, mon_e.root);
        end
      end
    end
  end

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    din = 32'hFFFF_FFFF; en = 1'b1; sof = 1'b1; eof = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q !== 16'h0 || q_en !== 1'b0 || q_sof !== 1'b0 || q_eof !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got data=%h en=%b sof=%b eof=%b, want 0 0 0 0", q, q_en, q_sof, q_eof);
    end
    total++;
    if (q_rst !== 1'b1) begin
      bad++;
      $display("FAIL rst_passthrough: got %b, want 1", q_rst);
    end
    total++;
    if (q_clk !== clk) begin
      bad++;
      $display("FAIL clk_passthrough: got %b, want %b", q_clk, clk);
    end
    rst = 1'b0;
    din = '0; en = 1'b0; sof = 1'b0; eof = 1'b0;
    #1;
    total++;
    if (q_rst !== 1'b0) begin
      bad++;
      $display("FAIL rst_release_passthrough: got %b, want 0", q_rst);
    end
    mon_on = 1'b1;
    seen = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      if (q_en !== 1'b0) seen = 1'b1;
      drive(32'h0, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL idle_after_reset: got en_o=1 during idle window, want 0");
    end
  endtask

  task automatic test_single();
    logic [31:0] xs  [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    logic [15:0] exp [5] = '{16'd0, 16'd1, 16'd1, 16'd1, 16'd2};
    logic early;
    for (int unsigned k = 0; k < 5; k++) begin
      drive(xs[k], 1'b1, 1'b0, 1'b0);
      early = 1'b0;
      for (int unsigned i = 1; i < LAT; i++) begin
        if (q_en !== 1'b0) early = 1'b1;
        drive(32'h0, 1'b0, 1'b0, 1'b0);
      end
      total++;
      if (early || q_en !== 1'b1 || q !== exp[k]) begin
        bad++;
        $display("FAIL single_latency[%0d]: got en_o=%b data=%h early=%b, want en_o=1 data=%h early=0",
                 k, q_en, q, early, exp[k]);
      end
      drive(32'h0, 1'b0, 1'b0, 1'b0);
      total++;
      if (q_en !== 1'b0) begin
        bad++;
        $display("FAIL single_pulse[%0d]: got en_o=%b one cycle later, want 0", k, q_en);
      end
    end
  endtask

  task automatic check_burst(input string name, input logic [31:0] xs [6], input logic [15:0] exp [6],
                             input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(xs[i], 1'b1, 1'b0, 1'b0);
    for (int unsigned i = n; i < LAT; i++) drive(32'h0, 1'b0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < n; i++) begin
      total++;
      if (q_en !== 1'b1 || q !== exp[i]) begin
        bad++;
        $display("FAIL %s[%0d]: got en_o=%b data=%h, want en_o=1 data=%h", name, i, q_en, q, exp[i]);
      end
      drive(32'h0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs  [6] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'd1000000, 32'hFFFE_0001, 32'h0, 32'h0};
    logic [15:0] exp [6] = '{16'hFFFF, 16'h8000, 16'd1000, 16'hFFFF, 16'h0, 16'h0};
    check_burst("back_to_back", xs, exp, 4);
  endtask

  task automatic test_near_square();
    longint unsigned r1 = 255;
    longint unsigned r2 = 46341;
    logic [31:0] xs [6];
    logic [15:0] exp [6] = '{16'd254, 16'd255, 16'd255, 16'd46340, 16'd46341, 16'd46341};
    xs[0] = 32'(r1*r1 - 1); xs[1] = 32'(r1*r1); xs[2] = 32'(r1*r1 + 2*r1);
    xs[3] = 32'(r2*r2 - 1); xs[4] = 32'(r2*r2); xs[5] = 32'(r2*r2 + 2*r2);
    check_burst("near_square", xs, exp, 6);
  endtask

  task automatic test_framing();
    int unsigned n_sof = 0, n_eof = 0, n_en = 0;
    int unsigned steps = 8 + 1 + 1 + LAT + 2;
    for (int unsigned i = 0; i < steps; i++) begin
      if (q_sof === 1'b1) n_sof++;
      if (q_eof === 1'b1) n_eof++;
      if (q_en  === 1'b1) n_en++;
      if (i < 8)       drive($urandom, 1'b1, i == 0, i == 7);
      else if (i == 8) drive($urandom, 1'b1, 1'b1, 1'b1);
      else if (i == 9) drive($urandom, 1'b0, 1'b1, 1'b1);
      else             drive(32'h0, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (n_sof != 2) begin
      bad++;
      $display("FAIL framing_sof_count: got %0d, want 2", n_sof);
    end
    total++;
    if (n_eof != 2) begin
      bad++;
      $display("FAIL framing_eof_count: got %0d, want 2", n_eof);
    end
    total++;
    if (n_en != 9) begin
      bad++;
      $display("FAIL framing_en_count: got %0d, want 9", n_en);
    end
  endtask

  task automatic test_random();
    int unsigned n_in = 0, n_out = 0;
    logic e;
    for (int unsigned i = 0; i < 30000 + LAT + 2; i++) begin
      if (q_en === 1'b1) n_out++;
      if (i < 30000) begin
        e = ($urandom_range(0, 3) != 0);
        if (e) n_in++;
        drive($urandom, e, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
      end else begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
      end
    end
    total++;
    if (n_out != n_in) begin
      bad++;
      $display("FAIL random_count: got %0d outputs, want %0d", n_out, n_in);
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    for (int unsigned i = 0; i < 10; i++) drive($urandom, 1'b1, i == 0, 1'b0);
    sb.delete();
    rst = 1'b1;
    din = 32'h1234_5678; en = 1'b1; sof = 1'b0; eof = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      if (q_en !== 1'b0) seen = 1'b1;
      drive(32'h0, 1'b0, 1'b0, 1'b0);
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_quiet: got en_o=1 after mid-stream reset, want 0");
    end
    drive(32'h0001_0000, 1'b1, 1'b0, 1'b0);
    for (int unsigned i = 1; i < LAT; i++) drive(32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (q_en !== 1'b1 || q !== 16'd256) begin
      bad++;
      $display("FAIL reset_mid_next: got en_o=%b data=%h, want en_o=1 data=0100", q_en, q);
    end
    repeat (3) drive(32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_near_square();
    test_framing();
    test_random();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
